// File: rtl/sr_latch_monitor.sv
// Purpose: synchronise, debounce and classify the Q/Qbar outputs of a free-running NAND SR latch.
// Latency: a pin change before edge k commits at edge k+2+STABLE_CYCLES; all outputs are registered.
// Backpressure: none; inputs are sampled every cycle and events are unacknowledged one-cycle pulses.
//
// Ports:
//   clk          single clock for the whole block
//   rst_n        asynchronous active-low reset
//   q_async      latch Q, asynchronous to clk
//   qbar_async   latch Qbar, asynchronous to clk
//   clr_cnt      synchronous clear of toggle_cnt (wins over a same-cycle increment)
//   state        committed state: 00 UNKNOWN, 01 SET, 10 RESET, 11 INVALID
//   valid        state is not UNKNOWN
//   set_evt      one-cycle pulse on commit into SET
//   rst_evt      one-cycle pulse on commit into RESET
//   invalid_evt  one-cycle pulse on commit into INVALID
//   toggle_cnt   saturating count of SET<->RESET commits
module sr_latch_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_async,
    input  logic             qbar_async,
    input  logic             clr_cnt,
    output logic [1:0]       state,
    output logic             valid,
    output logic             set_evt,
    output logic             rst_evt,
    output logic             invalid_evt,
    output logic [CNT_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_SET     = 2'b01,
        ST_RESET   = 2'b10,
        ST_INVALID = 2'b11
    } state_t;

    // Sampled {Q, Qbar} codes. 00 cannot be held by a NAND latch, so it
    // only ever appears mid-transition and is never committed.
    localparam logic [1:0] CODE_GLITCH  = 2'b00;
    localparam logic [1:0] CODE_RESET   = 2'b01;
    localparam logic [1:0] CODE_SET     = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    // Stability counter runs 0..STABLE_CYCLES-1; keep it at least one bit
    // wide so STABLE_CYCLES = 1 still elaborates.
    localparam int               SCW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SCW-1:0]   STAB_MAX = SCW'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Reset zeros decode as GLITCH, so nothing can
    // commit from the reset values themselves.
    // ------------------------------------------------------------------
    logic q_meta;
    logic q_s;
    logic qbar_meta;
    logic qbar_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta    <= 1'b0;
            q_s       <= 1'b0;
            qbar_meta <= 1'b0;
            qbar_s    <= 1'b0;
        end else begin
            q_meta    <= q_async;
            q_s       <= q_meta;
            qbar_meta <= qbar_async;
            qbar_s    <= qbar_meta;
        end
    end

    logic [1:0] code;
    assign code = {q_s, qbar_s};

    // ------------------------------------------------------------------
    // Debounce: any change of the sampled code reloads the candidate and
    // restarts the count; the count parks at its maximum while the code holds.
    // ------------------------------------------------------------------
    logic [1:0]     cand;
    logic [SCW-1:0] stab_cnt;
    logic           stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= CODE_GLITCH;
            stab_cnt <= '0;
        end else if (code != cand) begin
            cand     <= code;
            stab_cnt <= '0;
        end else if (stab_cnt < STAB_MAX) begin
            stab_cnt <= stab_cnt + SCW'(1);
        end
    end

    assign stable = (code == cand) && (stab_cnt == STAB_MAX);

    // Candidate code to state; GLITCH maps to UNKNOWN and is filtered below.
    state_t cand_state;

    always_comb begin
        cand_state = ST_UNKNOWN;
        case (cand)
            CODE_SET:     cand_state = ST_SET;
            CODE_RESET:   cand_state = ST_RESET;
            CODE_INVALID: cand_state = ST_INVALID;
            default:      cand_state = ST_UNKNOWN;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine. UNKNOWN is left on the first commit and only re-entered
    // through rst_n; a commit happens only when the stable candidate names a
    // state different from the current one, so a held state never re-fires.
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   commit;
    logic   toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNKNOWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        toggle  = 1'b0;
        if (stable && (cand != CODE_GLITCH) && (cand_state != state_q)) begin
            commit  = 1'b1;
            state_d = cand_state;
            // Only direct SET<->RESET flips count; entries from UNKNOWN or
            // INVALID are not toggles.
            toggle  = ((state_q == ST_SET)   && (cand_state == ST_RESET)) ||
                      ((state_q == ST_RESET) && (cand_state == ST_SET));
        end
    end

    // Registered outputs, updated on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            set_evt     <= 1'b0;
            rst_evt     <= 1'b0;
            invalid_evt <= 1'b0;
        end else begin
            valid       <= (state_d != ST_UNKNOWN);
            set_evt     <= commit && (state_d == ST_SET);
            rst_evt     <= commit && (state_d == ST_RESET);
            invalid_evt <= commit && (state_d == ST_INVALID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (clr_cnt) begin
            toggle_cnt <= '0;
        end else if (toggle && !(&toggle_cnt)) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
module tb_sr_latch_monitor;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic       q_async;
    logic       qbar_async;
    logic       clr_cnt;

    logic [1:0] state;
    logic       valid;
    logic       set_evt;
    logic       rst_evt;
    logic       invalid_evt;
    logic [7:0] toggle_cnt;

    logic [1:0] state_b;
    logic       valid_b;
    logic       set_evt_b;
    logic       rst_evt_b;
    logic       invalid_evt_b;
    logic [1:0] toggle_cnt_b;

    int checks;
    int errors;

    sr_latch_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .q_async(q_async), .qbar_async(qbar_async),
        .clr_cnt(clr_cnt), .state(state), .valid(valid), .set_evt(set_evt),
        .rst_evt(rst_evt), .invalid_evt(invalid_evt), .toggle_cnt(toggle_cnt)
    );

    sr_latch_monitor #(.STABLE_CYCLES(S), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .q_async(q_async), .qbar_async(qbar_async),
        .clr_cnt(clr_cnt), .state(state_b), .valid(valid_b), .set_evt(set_evt_b),
        .rst_evt(rst_evt_b), .invalid_evt(invalid_evt_b), .toggle_cnt(toggle_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the pins pass through a two-stage delay; a code
    // commits once the last S+1 synchronised samples are identical, non-00,
    // and name a state different from the current one.
    // ------------------------------------------------------------------
    logic [1:0] m_first;
    logic [1:0] m_hist [0:S];
    logic [1:0] m_state;
    logic [7:0] m_cnt8;
    logic [1:0] m_cnt2;
    logic       m_set;
    logic       m_rst;
    logic       m_inv;

    function automatic logic [1:0] code_to_state(input logic [1:0] c);
        if (c == 2'b10) return 2'b01;
        if (c == 2'b01) return 2'b10;
        if (c == 2'b11) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_first = 2'b00;
        for (int i = 0; i <= S; i++) m_hist[i] = 2'b00;
        m_state = 2'b00;
        m_cnt8  = 8'd0;
        m_cnt2  = 2'd0;
        m_set   = 1'b0;
        m_rst   = 1'b0;
        m_inv   = 1'b0;
    endtask

    task automatic model_step();
        bit         same;
        bit         commit;
        bit         flip;
        logic [1:0] ns;
        if (!rst_n) begin
            model_reset();
        end else begin
            same = 1'b1;
            for (int i = 1; i <= S; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
            ns     = code_to_state(m_hist[0]);
            commit = same && (m_hist[0] != 2'b00) && (ns != m_state);
            flip   = commit && (((m_state == 2'b01) && (ns == 2'b10)) ||
                                ((m_state == 2'b10) && (ns == 2'b01)));
            m_set  = commit && (ns == 2'b01);
            m_rst  = commit && (ns == 2'b10);
            m_inv  = commit && (ns == 2'b11);
            if (clr_cnt) begin
                m_cnt8 = 8'd0;
                m_cnt2 = 2'd0;
            end else if (flip) begin
                if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
                if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 2'd1;
            end
            if (commit) m_state = ns;
            for (int i = S; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_first;
            m_first   = {q_async, qbar_async};
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pins(input logic q, input logic qb);
        q_async    = q;
        qbar_async = qb;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clr_cnt = 1'b0;
        pins(1'b1, 1'b0);
        model_reset();
        repeat (3) tick();
        checks++;
        if ({state, valid, set_evt, rst_evt, invalid_evt} !== 6'b0 || toggle_cnt !== 8'd0 || toggle_cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: state=%b valid=%b evts=%b%b%b cnt=%0d cnt_b=%0d required all 0",
                     state, valid, set_evt, rst_evt, invalid_evt, toggle_cnt, toggle_cnt_b);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (state !== 2'b00 || valid !== 1'b0 || {set_evt, rst_evt, invalid_evt} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_quiet edge %0d: state=%b valid=%b evts=%b%b%b required 00/0/000",
                         e, state, valid, set_evt, rst_evt, invalid_evt);
            end
        end
        tick();
        checks++;
        if (state !== 2'b01 || valid !== 1'b1 || {set_evt, rst_evt, invalid_evt} !== 3'b100 || toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL first_set edge 7: state=%b valid=%b evts=%b%b%b cnt=%0d required 01/1/100/0",
                     state, valid, set_evt, rst_evt, invalid_evt, toggle_cnt);
        end
        tick();
        checks++;
        if (state !== 2'b01 || set_evt !== 1'b0) begin
            errors++;
            $display("FAIL set_evt_single_cycle: state=%b set_evt=%b required 01/0", state, set_evt);
        end
    endtask

    task automatic test_set_to_reset();
        pins(1'b0, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (state !== 2'b01 || {set_evt, rst_evt, invalid_evt} !== 3'b000) begin
                errors++;
                $display("FAIL set_to_reset_wait edge k+%0d: state=%b evts=%b%b%b required 01/000",
                         e - 1, state, set_evt, rst_evt, invalid_evt);
            end
        end
        tick();
        checks++;
        if (state !== 2'b10 || {set_evt, rst_evt, invalid_evt} !== 3'b010 || toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL set_to_reset_commit: state=%b evts=%b%b%b cnt=%0d required 10/010/1",
                     state, set_evt, rst_evt, invalid_evt, toggle_cnt);
        end
        tick();
        checks++;
        if (rst_evt !== 1'b0) begin
            errors++;
            $display("FAIL rst_evt_single_cycle: rst_evt=%b required 0", rst_evt);
        end
    endtask

    task automatic test_short_pulse();
        pins(1'b1, 1'b0);
        repeat (7) tick();
        checks++;
        if (state !== 2'b01 || set_evt !== 1'b1 || toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL back_to_set: state=%b set_evt=%b cnt=%0d required 01/1/2", state, set_evt, toggle_cnt);
        end
        tick();
        pins(1'b0, 1'b1);
        repeat (3) tick();
        pins(1'b1, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (state !== 2'b01 || {set_evt, rst_evt, invalid_evt} !== 3'b000) begin
                errors++;
                $display("FAIL short_pulse_filtered cycle %0d: state=%b evts=%b%b%b required 01/000",
                         e, state, set_evt, rst_evt, invalid_evt);
            end
        end
        checks++;
        if (toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL short_pulse_count: cnt=%0d required 2", toggle_cnt);
        end
    endtask

    task automatic test_invalid();
        pins(1'b0, 1'b1);
        repeat (7) tick();
        checks++;
        if (state !== 2'b10 || rst_evt !== 1'b1 || toggle_cnt !== 8'd3) begin
            errors++;
            $display("FAIL invalid_setup: state=%b rst_evt=%b cnt=%0d required 10/1/3", state, rst_evt, toggle_cnt);
        end
        pins(1'b1, 1'b1);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (state !== ((e < 7) ? 2'b10 : 2'b11) ||
                {set_evt, rst_evt, invalid_evt} !== ((e == 7) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL enter_invalid cycle %0d: state=%b evts=%b%b%b", e, state, set_evt, rst_evt, invalid_evt);
            end
        end
        pins(1'b0, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (state !== ((e < 7) ? 2'b11 : 2'b10) ||
                {set_evt, rst_evt, invalid_evt} !== ((e == 7) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL leave_invalid cycle %0d: state=%b evts=%b%b%b", e, state, set_evt, rst_evt, invalid_evt);
            end
        end
        checks++;
        if (toggle_cnt !== 8'd3 || toggle_cnt_b !== 2'd3) begin
            errors++;
            $display("FAIL invalid_no_count: cnt=%0d cnt_b=%0d required 3/3", toggle_cnt, toggle_cnt_b);
        end
        pins(1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (state !== 2'b10 || {set_evt, rst_evt, invalid_evt} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_code_held cycle %0d: state=%b evts=%b%b%b required 10/000",
                         e, state, set_evt, rst_evt, invalid_evt);
            end
        end
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (toggle_cnt !== 8'd0 || toggle_cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL clr_cnt: cnt=%0d cnt_b=%0d required 0/0", toggle_cnt, toggle_cnt_b);
        end
        for (int t = 1; t <= 5; t++) begin
            if (t % 2 == 1) pins(1'b1, 1'b0);
            else            pins(1'b0, 1'b1);
            repeat (7) tick();
            checks++;
            if (toggle_cnt !== 8'(t) || toggle_cnt_b !== 2'((t > 3) ? 3 : t) ||
                {set_evt, rst_evt} !== ((t % 2 == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL toggle_count %0d: cnt=%0d cnt_b=%0d evts=%b%b", t, toggle_cnt, toggle_cnt_b, set_evt, rst_evt);
            end
        end
        pins(1'b0, 1'b1);
        repeat (6) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (rst_evt !== 1'b1 || state !== 2'b10 || toggle_cnt !== 8'd0 || toggle_cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL clr_beats_toggle: rst_evt=%b state=%b cnt=%0d cnt_b=%0d required 1/10/0/0",
                     rst_evt, state, toggle_cnt, toggle_cnt_b);
        end
    endtask

    task automatic test_reset_mid_debounce();
        pins(1'b1, 1'b0);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({state, valid, set_evt, rst_evt, invalid_evt} !== 6'b0 || toggle_cnt !== 8'd0 || toggle_cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: state=%b valid=%b evts=%b%b%b cnt=%0d required all 0",
                     state, valid, set_evt, rst_evt, invalid_evt, toggle_cnt);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (state !== 2'b00 || valid !== 1'b0 || {set_evt, rst_evt, invalid_evt} !== 3'b000) begin
                errors++;
                $display("FAIL mid_reset_quiet edge %0d: state=%b valid=%b evts=%b%b%b required 00/0/000",
                         e, state, valid, set_evt, rst_evt, invalid_evt);
            end
        end
        tick();
        checks++;
        if (state !== 2'b01 || valid !== 1'b1 || set_evt !== 1'b1 || toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_recover: state=%b valid=%b set_evt=%b cnt=%0d required 01/1/1/0",
                     state, valid, set_evt, toggle_cnt);
        end
    endtask

    task automatic test_random();
        int run_left;
        int rst_hold;
        run_left = 0;
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            clr_cnt = ($urandom_range(0, 99) < 3);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                rst_hold = 2;
            end
            tick();
            checks++;
            if (state !== m_state || valid !== (m_state != 2'b00) ||
                {set_evt, rst_evt, invalid_evt} !== {m_set, m_rst, m_inv} || toggle_cnt !== m_cnt8) begin
                errors++;
                $display("FAIL random cycle %0d: state=%b valid=%b evts=%b%b%b cnt=%0d model state=%b evts=%b%b%b cnt=%0d",
                         c, state, valid, set_evt, rst_evt, invalid_evt, toggle_cnt, m_state, m_set, m_rst, m_inv, m_cnt8);
            end
            checks++;
            if (state_b !== m_state || valid_b !== (m_state != 2'b00) ||
                {set_evt_b, rst_evt_b, invalid_evt_b} !== {m_set, m_rst, m_inv} || toggle_cnt_b !== m_cnt2) begin
                errors++;
                $display("FAIL random_w2 cycle %0d: state=%b evts=%b%b%b cnt=%0d model state=%b cnt=%0d",
                         c, state_b, set_evt_b, rst_evt_b, invalid_evt_b, toggle_cnt_b, m_state, m_cnt2);
            end
        end
        rst_n   = 1'b1;
        clr_cnt = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_set_to_reset();
        test_short_pulse();
        test_invalid();
        test_saturation();
        test_reset_mid_debounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
